tbird_button_conditioner: RTL and testbench

//  Producer side of the turn-signal FSM's pushbutton interface. Takes raw, bouncy,

---
 rtl/tbird_button_conditioner_if.sv | 21 ++
 rtl/tbird_button_conditioner.sv | 141 ++++++++++++++
 tb/tb_tbird_button_conditioner.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/tbird_button_conditioner_if.sv
// Pushbutton link between raw KEY pins, the conditioner and the turn-signal FSM.
// The master modport is the conditioner; the slave modport is the key source / consumer.
interface tbird_button_conditioner_if;
  logic       key_right_n;
  logic       key_left_n;
  logic       key_hazard_n;
  logic       right_button;
  logic       left_button;
  logic       hazard_button;
  logic [2:0] press_pulse;

  modport master (
    input  key_right_n, key_left_n, key_hazard_n,
    output right_button, left_button, hazard_button, press_pulse
  );

  modport slave (
    output key_right_n, key_left_n, key_hazard_n,
    input  right_button, left_button, hazard_button, press_pulse
  );
endinterface

// File: rtl/tbird_button_conditioner.sv
// Synchronizes and debounces the three active-low KEYs, enforces left/right exclusion.
// Define HAZARD_LATCH_EN to make hazard_button toggle on each accepted press.
module tbird_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic                       clock,
  input  logic                       reset,
  tbird_button_conditioner_if.master btn
);
  typedef enum logic [1:0] {REL, PRESS_P, PRS, REL_P} deb_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order everywhere: {hazard, left, right}
  logic [2:0] key_raw_n;
  logic [2:0] press_evt;
  logic [2:0] release_evt;

  assign key_raw_n = {btn.key_hazard_n, btn.key_left_n, btn.key_right_n};

  for (genvar gi = 0; gi < 3; gi++) begin : g_key
    logic             s1_reg;
    logic             s2_reg;
    deb_state_t       state_reg;
    deb_state_t       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clock) begin
      if (reset) begin
        s1_reg    <= 1'b1;
        s2_reg    <= 1'b1;
        state_reg <= REL;
        cnt_reg   <= '0;
      end else begin
        s1_reg    <= key_raw_n[gi];
        s2_reg    <= s1_reg;
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
      end
    end

    // Pending states count stable samples; cnt stops at CNT_MAX because the move fires there.
    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
        REL: begin
          if (!s2_reg) begin
            state_next = PRESS_P;
            cnt_next   = '0;
          end
        end
        PRESS_P: begin
          if (s2_reg) begin
            state_next = REL;
            cnt_next   = '0;
          end else if (cnt_reg == CNT_MAX) begin
            state_next = PRS;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        PRS: begin
          if (s2_reg) begin
            state_next = REL_P;
            cnt_next   = '0;
          end
        end
        REL_P: begin
          if (!s2_reg) begin
            state_next = PRS;
            cnt_next   = '0;
          end else if (cnt_reg == CNT_MAX) begin
            state_next = REL;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = REL;
          cnt_next   = '0;
        end
      endcase
    end

    assign press_evt[gi]   = (state_reg == PRESS_P) && (state_next == PRS);
    assign release_evt[gi] = (state_reg == REL_P) && (state_next == REL);
  end

  logic       right_reg, right_next;
  logic       left_reg, left_next;
  logic       hazard_reg, hazard_next;
  logic       right_grant, left_grant;
  logic [2:0] accept_reg;
  logic [2:0] press_pulse_reg;

  // A turn key is granted only at its press edge; right wins a simultaneous press.
  assign right_grant = press_evt[0] && left_reg;
  assign left_grant  = press_evt[1] && right_reg && !right_grant;

  always_comb begin
    right_next  = right_reg;
    left_next   = left_reg;
    hazard_next = hazard_reg;
    if (release_evt[0]) right_next = 1'b1;
    else if (right_grant) right_next = 1'b0;
    if (release_evt[1]) left_next = 1'b1;
    else if (left_grant) left_next = 1'b0;
`ifdef HAZARD_LATCH_EN
    if (press_evt[2]) hazard_next = ~hazard_reg;
`else
    if (release_evt[2]) hazard_next = 1'b1;
    else if (press_evt[2]) hazard_next = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      right_reg       <= 1'b1;
      left_reg        <= 1'b1;
      hazard_reg      <= 1'b1;
      accept_reg      <= '0;
      press_pulse_reg <= '0;
    end else begin
      right_reg       <= right_next;
      left_reg        <= left_next;
      hazard_reg      <= hazard_next;
      accept_reg      <= {press_evt[2], left_grant, right_grant};
      press_pulse_reg <= accept_reg;
    end
  end

  assign btn.right_button  = right_reg;
  assign btn.left_button   = left_reg;
  assign btn.hazard_button = hazard_reg;
  assign btn.press_pulse   = press_pulse_reg;
endmodule

// File: tb/tb_tbird_button_conditioner.sv
// Directed bench for tbird_button_conditioner with DEBOUNCE_CYCLES=4.
module tb_tbird_button_conditioner;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic hz_before;
  logic hz_pressed;
  logic hz_released;

  tbird_button_conditioner_if intf ();

  tbird_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn  (intf.master)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Observed/expected packed as {hazard, left, right, press_pulse[2:0]}
  task automatic chk(input string tag, input logic h, input logic l, input logic r,
                     input logic [2:0] p);
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {intf.hazard_button, intf.left_button, intf.right_button, intf.press_pulse};
    exp = {h, l, r, p};
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed {h,l,r,pulse}=%b expected %b", tag, obs, exp);
      end
    $display("check %0d %s: {h,l,r,pulse}=%b", checks, tag, obs);
  endtask

  initial begin
    intf.key_right_n  = 1'b1;
    intf.key_left_n   = 1'b1;
    intf.key_hazard_n = 1'b1;

    // 1: reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("reset", 1'b1, 1'b1, 1'b1, 3'b000);
    end
    reset = 1'b0;
    step(2);
    chk("idle", 1'b1, 1'b1, 1'b1, 3'b000);

    // 2: clean right press, output at k+6, pulse at k+7 only
    intf.key_right_n = 1'b0;
    step(6);
    chk("right_k5", 1'b1, 1'b1, 1'b1, 3'b000);
    step(1);
    chk("right_k6", 1'b1, 1'b1, 1'b0, 3'b000);
    step(1);
    chk("right_pulse", 1'b1, 1'b1, 1'b0, 3'b001);
    step(1);
    chk("right_pulse_end", 1'b1, 1'b1, 1'b0, 3'b000);
    intf.key_right_n = 1'b1;
    step(6);
    chk("right_rel_k5", 1'b1, 1'b1, 1'b0, 3'b000);
    step(1);
    chk("right_rel_k6", 1'b1, 1'b1, 1'b1, 3'b000);
    step(3);

    // 3: left bounces, never stable for four cycles
    for (int b = 0; b < 3; b++) begin
      intf.key_left_n = 1'b0;
      for (int i = 0; i < 3 - (b / 2); i++) begin
        step(1);
        chk("left_bounce_lo", 1'b1, 1'b1, 1'b1, 3'b000);
      end
      intf.key_left_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
        step(1);
        chk("left_bounce_hi", 1'b1, 1'b1, 1'b1, 3'b000);
      end
    end
    step(8);
    chk("left_bounce_end", 1'b1, 1'b1, 1'b1, 3'b000);

    // Reset mid-ownership discards progress; still-held key is re-debounced afterwards
    intf.key_right_n = 1'b0;
    step(9);
    chk("right_before_rst", 1'b1, 1'b1, 1'b0, 3'b000);
    reset = 1'b1;
    step(1);
    chk("mid_reset", 1'b1, 1'b1, 1'b1, 3'b000);
    reset = 1'b0;
    step(6);
    chk("post_rst_k5", 1'b1, 1'b1, 1'b1, 3'b000);
    step(1);
    chk("post_rst_k6", 1'b1, 1'b1, 1'b0, 3'b000);
    step(1);
    chk("post_rst_pulse", 1'b1, 1'b1, 1'b0, 3'b001);
    step(1);

    // 4: right owns, left blocked, owner release does not grant left
    intf.key_left_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("left_blocked", 1'b1, 1'b1, 1'b0, 3'b000);
    end
    intf.key_right_n = 1'b1;
    step(7);
    chk("right_rel_left_held", 1'b1, 1'b1, 1'b1, 3'b000);
    step(5);
    chk("left_still_blocked", 1'b1, 1'b1, 1'b1, 3'b000);
    intf.key_left_n = 1'b1;
    step(8);
    intf.key_left_n = 1'b0;
    step(6);
    chk("left_repress_k5", 1'b1, 1'b1, 1'b1, 3'b000);
    step(1);
    chk("left_repress_k6", 1'b1, 1'b0, 1'b1, 3'b000);
    step(1);
    chk("left_pulse", 1'b1, 1'b0, 1'b1, 3'b010);
    step(1);
    chk("left_pulse_end", 1'b1, 1'b0, 1'b1, 3'b000);
    intf.key_left_n = 1'b1;
    step(8);
    chk("left_released", 1'b1, 1'b1, 1'b1, 3'b000);

    // 5: simultaneous press, right has priority
    intf.key_right_n = 1'b0;
    intf.key_left_n  = 1'b0;
    step(7);
    chk("both_k6", 1'b1, 1'b1, 1'b0, 3'b000);
    step(1);
    chk("both_pulse", 1'b1, 1'b1, 1'b0, 3'b001);
    step(1);
    chk("both_pulse_end", 1'b1, 1'b1, 1'b0, 3'b000);
    intf.key_right_n = 1'b1;
    intf.key_left_n  = 1'b1;
    step(8);
    chk("both_released", 1'b1, 1'b1, 1'b1, 3'b000);

    // 6: hazard pressed and released twice
    hz_before = 1'b1;
    for (int p = 0; p < 2; p++) begin
`ifdef HAZARD_LATCH_EN
      hz_pressed  = ~hz_before;
      hz_released = hz_pressed;
`else
      hz_pressed  = 1'b0;
      hz_released = 1'b1;
`endif
      intf.key_hazard_n = 1'b0;
      step(6);
      chk("hazard_k5", hz_before, 1'b1, 1'b1, 3'b000);
      step(1);
      chk("hazard_k6", hz_pressed, 1'b1, 1'b1, 3'b000);
      step(1);
      chk("hazard_pulse", hz_pressed, 1'b1, 1'b1, 3'b100);
      step(1);
      chk("hazard_pulse_end", hz_pressed, 1'b1, 1'b1, 3'b000);
      intf.key_hazard_n = 1'b1;
      step(6);
      chk("hazard_rel_k5", hz_pressed, 1'b1, 1'b1, 3'b000);
      step(1);
      chk("hazard_rel_k6", hz_released, 1'b1, 1'b1, 3'b000);
      step(3);
      hz_before = hz_released;
    end

    // Hazard is independent of a turn key that owns its output
    intf.key_right_n  = 1'b0;
    intf.key_hazard_n = 1'b0;
`ifdef HAZARD_LATCH_EN
    hz_pressed = ~hz_before;
`else
    hz_pressed = 1'b0;
`endif
    step(7);
    chk("hazard_and_right", hz_pressed, 1'b1, 1'b0, 3'b000);
    step(1);
    chk("hazard_right_pulse", hz_pressed, 1'b1, 1'b0, 3'b101);
    intf.key_right_n  = 1'b1;
    intf.key_hazard_n = 1'b1;
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
